// File: rtl/inv_mix_w_pipe_if.sv
// Handshake bundle for the inv_mix_w_pipe column engine: upstream word port,
// downstream word port and the synchronous flush.
interface inv_mix_w_pipe_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_round;
   logic [31:0] in_key;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_col;
   logic        out_last;
   logic        out_round_err;

   // valid/ready on both sides: a word moves on any cycle where valid && ready;
   // a producer holding valid keeps its payload stable until that cycle.
   modport master (
      output flush, in_valid, in_round, in_key, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_col, out_last, out_round_err
   );
   modport slave (
      input  flush, in_valid, in_round, in_key, in_data, out_ready,
      output in_ready, out_valid, out_data, out_col, out_last, out_round_err
   );
endinterface

// File: rtl/inv_mix_w_pipe.sv
// Decryption column engine: AddRoundKey then InvMixColumns on one 32-bit column.
// Define INV_MIX_W_PIPE2_EN for the two-stage (latency 2) pipeline.
module inv_mix_w_pipe #(
   parameter int LAST_ROUND = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   inv_mix_w_pipe_if.slave  bus
);
   localparam logic [4:0] LAST_R = 5'(LAST_ROUND);

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] v, input logic [3:0] c);
      logic [7:0] v2, v4, v8;
      v2 = xt(v);
      v4 = xt(v2);
      v8 = xt(v4);
      return (c[0] ? v : 8'h00) ^ (c[1] ? v2 : 8'h00) ^
             (c[2] ? v4 : 8'h00) ^ (c[3] ? v8 : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] t);
      logic [7:0] a, b, c, d;
      a = t[31:24];
      b = t[23:16];
      c = t[15:8];
      d = t[7:0];
      return {gmul(a, 4'he) ^ gmul(b, 4'hb) ^ gmul(c, 4'hd) ^ gmul(d, 4'h9),
              gmul(b, 4'he) ^ gmul(c, 4'hb) ^ gmul(d, 4'hd) ^ gmul(a, 4'h9),
              gmul(c, 4'he) ^ gmul(d, 4'hb) ^ gmul(a, 4'hd) ^ gmul(b, 4'h9),
              gmul(d, 4'he) ^ gmul(a, 4'hb) ^ gmul(b, 4'hd) ^ gmul(c, 4'h9)};
   endfunction

   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic        out_err_q, out_err_d;
   logic [1:0]  col_q, col_d;
   logic        out_free, out_fire, accept;
   logic [31:0] in_t;
   logic        in_bypass, in_err;
   logic [4:0]  round_w;

   assign round_w   = {1'b0, bus.in_round};
   assign in_t      = bus.in_data ^ bus.in_key;
   // First and last rounds (and out-of-range ones) are key-add only.
   assign in_bypass = (bus.in_round == 4'd0) || (round_w >= LAST_R);
   assign in_err    = round_w > LAST_R;
   assign out_free  = !out_valid_q || bus.out_ready;
   assign out_fire  = out_valid_q && bus.out_ready && !bus.flush;

`ifdef INV_MIX_W_PIPE2_EN
   logic        s1_valid_q, s1_valid_d;
   logic [31:0] s1_t_q, s1_t_d;
   logic        s1_bypass_q, s1_bypass_d;
   logic        s1_err_q, s1_err_d;
   logic        s1_adv;

   assign s1_adv       = s1_valid_q && out_free;
   assign bus.in_ready = !bus.flush && (!s1_valid_q || s1_adv);
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_t_d      = s1_t_q;
      s1_bypass_d = s1_bypass_q;
      s1_err_d    = s1_err_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      if (bus.flush) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (accept) begin
            s1_valid_d  = 1'b1;
            s1_t_d      = in_t;
            s1_bypass_d = in_bypass;
            s1_err_d    = in_err;
         end else if (s1_adv) begin
            s1_valid_d = 1'b0;
         end
         if (s1_adv) begin
            out_valid_d = 1'b1;
            out_data_d  = s1_bypass_q ? s1_t_q : inv_mix(s1_t_q);
            out_err_d   = s1_err_q;
         end else if (out_fire) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_t_q      <= 32'h0;
         s1_bypass_q <= 1'b0;
         s1_err_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_t_q      <= s1_t_d;
         s1_bypass_q <= s1_bypass_d;
         s1_err_q    <= s1_err_d;
      end
   end
`else
   assign bus.in_ready = !bus.flush && out_free;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_bypass ? in_t : inv_mix(in_t);
         out_err_d   = in_err;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   // Counter tracks delivered columns only; a flushed word is never counted.
   assign col_d = bus.flush ? 2'd0 : (out_fire ? col_q + 2'd1 : col_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= 32'h0;
         out_err_q   <= 1'b0;
         col_q       <= 2'd0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         col_q       <= col_d;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = out_data_q;
   assign bus.out_round_err = out_err_q;
   assign bus.out_col       = col_q;
   assign bus.out_last      = (col_q == 2'd3);
endmodule

// File: tb/tb_inv_mix_w_pipe.sv
// Scoreboard bench for inv_mix_w_pipe: directed column vectors with
// hand-computed InvMixColumns results, decoupled driver and monitor.
`timescale 1ns/1ps
module tb_inv_mix_w_pipe;
   localparam int W = 33;
`ifdef INV_MIX_W_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [W-1:0] exp_q[$];
   logic [1:0]   exp_col = 2'd0;

   inv_mix_w_pipe_if bus();

   inv_mix_w_pipe #(.LAST_ROUND(14)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [3:0] rnd, input logic [31:0] key, input logic [31:0] data,
                       input logic [31:0] exp_data, input logic exp_err);
      bit done;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_round = rnd;
      bus.in_key   = key;
      bus.in_data  = data;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back({exp_err, exp_data});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: word %0h never accepted", data);
      end
   endtask

   task automatic drain();
      bus.in_valid = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst_n || bus.flush) begin
         exp_q.delete();
         exp_col = 2'd0;
      end else if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected no word", bus.out_data);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e[31:0]);
            chk("out_round_err", bus.out_round_err, e[32]);
            chk("out_col", bus.out_col, exp_col);
            chk("out_last", bus.out_last, exp_col == 2'd3);
            exp_col = exp_col + 2'd1;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_round  = 4'd0;
      bus.in_key    = 32'h0;
      bus.in_data   = 32'h0;
      bus.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_col", bus.out_col, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_round_err", bus.out_round_err, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single word, latency
      send(4'd5, 32'h0, 32'h8e4da1bc, 32'hdb135345, 1'b0);
      bus.in_valid = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         chk("latency_out_valid", bus.out_valid, k == LAT);
      end
      @(posedge clk);
      #1;
      drain();

      // restart the column count for the block test
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;

      // four back-to-back columns of one block
      fork
         begin
            send(4'd5, 32'h0, 32'h9fdc589d, 32'hf20a225c, 1'b0);
            send(4'd5, 32'h0, 32'h8e4da1bc, 32'hdb135345, 1'b0);
            send(4'd5, 32'h0, 32'h01010101, 32'h01010101, 1'b0);
            send(4'd5, 32'h0, 32'h9fdc589d, 32'hf20a225c, 1'b0);
            bus.in_valid = 1'b0;
         end
         begin
            int n, first, last;
            n = 0;
            first = -1;
            last = -1;
            for (int i = 0; i < LAT + 6; i++) begin
               @(negedge clk);
               if (bus.out_valid) begin
                  n++;
                  if (first < 0) first = i;
                  last = i;
               end
            end
            chk("burst_valid_cycles", n, 4);
            chk("burst_no_bubble", last - first, 3);
         end
      join
      drain();

      // key-add-only rounds and out-of-range round
      send(4'd0, 32'hffffffff, 32'h12345678, 32'hedcba987, 1'b0);
      send(4'd14, 32'hffffffff, 32'h12345678, 32'hedcba987, 1'b0);
      send(4'd15, 32'h0f0f0f0f, 32'h00000000, 32'h0f0f0f0f, 1'b1);
      drain();

      // backpressure
      bus.out_ready = 1'b0;
      fork
         begin
            send(4'd5, 32'h0, 32'h9fdc589d, 32'hf20a225c, 1'b0);
            send(4'd1, 32'h0, 32'h01010101, 32'h01010101, 1'b0);
            send(4'd13, 32'h0, 32'h8e4da1bc, 32'hdb135345, 1'b0);
            send(4'd15, 32'h0, 32'h12345678, 32'h12345678, 1'b1);
            bus.in_valid = 1'b0;
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
               @(negedge clk);
               if (bus.out_valid) seen = 1'b1;
            end
            chk("stall_out_valid", seen, 1);
            for (int i = 0; i < 3; i++) begin
               if (i > 0) @(negedge clk);
               chk("stall_out_data", bus.out_data, 32'hf20a225c);
            end
            chk("stall_in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // flush with a word in flight and a word offered
      send(4'd5, 32'h0, 32'h9fdc589d, 32'hf20a225c, 1'b0);
      send(4'd0, 32'h0, 32'hcafef00d, 32'hcafef00d, 1'b0);
      send(4'd5, 32'h0, 32'h01010101, 32'h01010101, 1'b0);
      bus.in_valid = 1'b0;
      repeat (LAT - 1) begin
         @(posedge clk);
         #1;
      end
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_round = 4'd5;
      bus.in_key   = 32'h0;
      bus.in_data  = 32'h8e4da1bc;
      @(negedge clk);
      chk("flush_in_ready", bus.in_ready, 0);
      chk("flush_pending_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", bus.out_valid, 0);
      @(posedge clk);
      #1;
      send(4'd5, 32'h0, 32'h8e4da1bc, 32'hdb135345, 1'b0);
      drain();

      // asynchronous reset mid-stream
      send(4'd5, 32'h0, 32'h9fdc589d, 32'hf20a225c, 1'b0);
      send(4'd5, 32'h0, 32'h8e4da1bc, 32'hdb135345, 1'b0);
      bus.in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_out_data", bus.out_data, 0);
      chk("midrst_out_col", bus.out_col, 0);
      chk("midrst_out_last", bus.out_last, 0);
      chk("midrst_out_round_err", bus.out_round_err, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_idle", bus.out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(4'd0, 32'h0, 32'h00c0ffee, 32'h00c0ffee, 1'b0);
      drain();

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
